// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM duty controller: duty width, preset table
// and the ramp FSM state encoding.
package pwm_ctrl_pkg;

  localparam int PWM_RES    = 8;
  localparam int NUM_LEVELS = 5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } state_t;

  // Preset duty for each level index; out-of-range indices map to off.
  function automatic logic [7:0] level_to_duty(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'd0;
      3'd1:    return 8'd64;
      3'd2:    return 8'd128;
      3'd3:    return 8'd191;
      3'd4:    return 8'd255;
      default: return 8'd0;
    endcase
  endfunction

  // Cyclic advance through the preset levels.
  function automatic logic [2:0] next_level(input logic [2:0] idx);
    return (idx == 3'(NUM_LEVELS - 1)) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/pwm_duty_sequencer_if.sv
// Control/status bundle between the duty sequencer and the PWM datapath.
// master: the sequencer (takes enable/key, produces tick and duty).
// slave:  the consumer side (board switches/keys and PWM datapath).
interface pwm_duty_sequencer_if #(
  parameter int PWM_RES = pwm_ctrl_pkg::PWM_RES
);
  logic               enable;
  logic               key_n;
  logic               pwm_tick;
  logic [PWM_RES-1:0] pwm_count;
  logic [2:0]         level;
  logic               busy;

  modport master (
    input  enable, key_n,
    output pwm_tick, pwm_count, level, busy
  );

  modport slave (
    output enable, key_n,
    input  pwm_tick, pwm_count, level, busy
  );
endinterface

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and a
// one-cycle press strobe on the accepted 1->0 transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic press_evt
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES > 1 ? DEBOUNCE_CYCLES : 2);

  logic          sync_1;
  logic          sync_2;
  logic          stable;
  logic [DW-1:0] cnt;
  logic          settled;

  // The synchronised input has differed from the stable value long enough.
  assign settled   = (sync_2 != stable) && (cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign press_evt = settled && !sync_2;

  // Synchronise the raw key and qualify level changes by their duration.
  // NOTE: non-blocking assignments make every flop sample pre-edge values,
  // which is what lets sync_1 -> sync_2 behave as a two-stage pipeline.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
    end else begin
      sync_1 <= key_n;
      sync_2 <= sync_1;
      if (sync_2 == stable) begin
        cnt <= '0;
      end else if (settled) begin
        stable <= sync_2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Steps one PWM channel through preset duty levels on debounced key presses,
// slewing the compare value one LSB per ramp interval, and generates the
// PWM counter enable strobe.
module pwm_duty_sequencer
  import pwm_ctrl_pkg::*;
#(
  parameter int CLK_DIV         = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RAMP_DIV        = 50000,
  parameter int PWM_RES         = pwm_ctrl_pkg::PWM_RES
) (
  input logic                  clock,
  input logic                  reset,
  pwm_duty_sequencer_if.master bus
);
  localparam int TW = $clog2(CLK_DIV > 1 ? CLK_DIV : 2);
  localparam int RW = $clog2(RAMP_DIV > 1 ? RAMP_DIV : 2);

  logic               press_evt;
  logic [2:0]         level;
  logic [TW-1:0]      tick_cnt;
  logic [RW-1:0]      ramp_cnt;
  logic               ramp_evt;
  logic [PWM_RES-1:0] target;
  logic [PWM_RES-1:0] count;
  logic [PWM_RES-1:0] count_next;
  state_t             state;
  state_t             state_next;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clock    (clock),
    .reset    (reset),
    .key_n    (bus.key_n),
    .press_evt(press_evt)
  );

  assign target   = PWM_RES'(level_to_duty(level));
  assign ramp_evt = (state != IDLE) && (ramp_cnt == RW'(RAMP_DIV - 1));

  // Level selection and the free-running tick prescaler.
  always_ff @(posedge clock) begin
    if (reset) begin
      level    <= '0;
      tick_cnt <= '0;
    end else begin
      if (press_evt && bus.enable) level <= next_level(level);
      if (!bus.enable || tick_cnt == TW'(CLK_DIV - 1)) tick_cnt <= '0;
      else                                             tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Step in the current direction, then pick the direction from the result,
  // so a simultaneous retarget only steers the following steps.
  // NOTE: defaults first keep this block free of inferred latches.
  always_comb begin
    count_next = count;
    state_next = state;
    case (state)
      RAMP_UP:   if (ramp_evt && count != '1) count_next = count + 1'b1;
      RAMP_DOWN: if (ramp_evt && count != '0) count_next = count - 1'b1;
      default:   ;
    endcase
    if (count_next < target)      state_next = RAMP_UP;
    else if (count_next > target) state_next = RAMP_DOWN;
    else                          state_next = IDLE;
    if (!bus.enable) begin
      state_next = IDLE;
      count_next = '0;
    end
  end

  // FSM state, duty value and ramp interval divider.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      ramp_cnt <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (state == IDLE || ramp_evt || !bus.enable) ramp_cnt <= '0;
      else                                          ramp_cnt <= ramp_cnt + 1'b1;
    end
  end

  assign bus.pwm_tick  = bus.enable && (tick_cnt == TW'(CLK_DIV - 1));
  assign bus.pwm_count = count;
  assign bus.level     = level;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Self-checking bench: a cycle model pushes expected outputs before every
// clock edge; they are popped and compared just after the edge. Directed
// checks cover latency, ramp length, saturation, retarget and enable.
module tb_pwm_duty_sequencer;
  localparam int CLK_DIV  = 4;
  localparam int DEB      = 8;
  localparam int RAMP_DIV = 2;

  typedef struct packed {
    logic [7:0] count;
    logic [2:0] level;
    logic       busy;
    logic       tick;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   mon_min, mon_max;
  exp_t sb_q[$];

  // Reference model state
  bit ms1, ms2, mstable;
  int mrun, mlevel, mcount, mdir, mramp, mtick;
  int preset[5] = '{0, 64, 128, 191, 255};

  pwm_duty_sequencer_if bus ();

  pwm_duty_sequencer #(
    .CLK_DIV(CLK_DIV), .DEBOUNCE_CYCLES(DEB), .RAMP_DIV(RAMP_DIV), .PWM_RES(8)
  ) dut (
    .clock(clk), .reset(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance the model by one clock edge and queue the post-edge outputs.
  task automatic model_step();
    exp_t e;
    int   tgt;
    bit   accept, press, evt;
    if (rst) begin
      ms1 = 1; ms2 = 1; mstable = 1; mrun = 0;
      mlevel = 0; mcount = 0; mdir = 0; mramp = 0; mtick = 0;
    end else begin
      tgt    = preset[mlevel];
      accept = 0;
      if (ms2 != mstable) begin
        mrun++;
        if (mrun == DEB) begin accept = 1; mrun = 0; end
      end else mrun = 0;
      press = accept && !ms2;
      if (accept) mstable = ms2;
      ms2 = ms1;
      ms1 = bus.key_n;
      if (press && bus.enable) mlevel = (mlevel == 4) ? 0 : mlevel + 1;
      if (!bus.enable) begin
        mcount = 0; mdir = 0; mramp = 0; mtick = 0;
      end else begin
        evt   = (mdir != 0) && (mramp == RAMP_DIV - 1);
        mramp = (mdir == 0 || evt) ? 0 : mramp + 1;
        if (evt) mcount = mcount + mdir;
        if (mcount > 255) mcount = 255;
        if (mcount < 0)   mcount = 0;
        mdir  = (mcount < tgt) ? 1 : (mcount > tgt) ? -1 : 0;
        mtick = (mtick + 1) % CLK_DIV;
      end
    end
    e.count = 8'(mcount);
    e.level = 3'(mlevel);
    e.busy  = (mdir != 0);
    e.tick  = bus.enable && (mtick == CLK_DIV - 1);
    sb_q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.pwm_count < mon_min) mon_min = bus.pwm_count;
    if (bus.pwm_count > mon_max) mon_max = bus.pwm_count;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check($sformatf("outputs_c%0d", cyc),
            32'({bus.pwm_count, bus.level, bus.busy, bus.pwm_tick}), 32'(e));
    end
  endtask

  task automatic press(input int hold);
    bus.key_n = 1'b0;
    repeat (hold) step();
    bus.key_n = 1'b1;
    repeat (DEB + 4) step();
  endtask

  task automatic wait_settle(input string tag);
    int n = 0;
    step();
    while (bus.busy && n < 1200) begin step(); n++; end
    check({tag, "_settled"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_count(input int v, input bit up, input string tag);
    int n = 0;
    while ((up ? (bus.pwm_count < v) : (bus.pwm_count > v)) && n < 1200) begin
      step(); n++;
    end
    check({tag, "_reached"}, 32'(up ? (bus.pwm_count >= v) : (bus.pwm_count <= v)), 32'd1);
  endtask

  initial begin
    int lat, t_rise, t_fall, ticks;
    mon_min = 255; mon_max = 0;
    bus.enable = 1'b1;
    bus.key_n  = 1'b0;

    // Reset with key held low
    rst = 1'b1;
    repeat (3) step();
    check("reset_count", 32'(bus.pwm_count), 32'd0);
    check("reset_level", 32'(bus.level),     32'd0);
    check("reset_busy",  32'(bus.busy),      32'd0);
    check("reset_tick",  32'(bus.pwm_tick),  32'd0);
    rst = 1'b0;
    bus.key_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("tick_k%0d", k), 32'(bus.pwm_tick), 32'((k % 4) == 3));
    end

    // Bouncing key never accepted
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) bus.key_n = ~bus.key_n;
      step();
    end
    bus.key_n = 1'b1;
    repeat (12) step();
    check("bounce_level", 32'(bus.level), 32'd0);

    // Clean press: latency, then the 0 -> 64 ramp
    lat = -1; t_rise = -1;
    bus.key_n = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (lat < 0 && bus.level == 3'd1) lat = k;
      if (t_rise < 0 && bus.busy) t_rise = cyc;
    end
    bus.key_n = 1'b1;
    check("press_latency", 32'(lat), 32'd10);
    wait_settle("ramp64");
    t_fall = cyc;
    check("ramp_cycles", 32'(t_fall - t_rise), 32'd128);
    check("ramp_final",  32'(bus.pwm_count),   32'd64);
    check("single_press_level", 32'(bus.level), 32'd1);

    // Up to level 4, saturate at 255, wrap to level 0 and ramp down
    press(12); wait_settle("lvl2");
    press(12); wait_settle("lvl3");
    press(12); wait_settle("lvl4");
    check("lvl4_level", 32'(bus.level),     32'd4);
    check("lvl4_count", 32'(bus.pwm_count), 32'd255);
    repeat (10) step();
    check("lvl4_hold", 32'({bus.pwm_count, bus.busy}), 32'({8'd255, 1'b0}));
    press(12);
    check("wrap_level", 32'(bus.level), 32'd0);
    check("ramp_down_seen", 32'(bus.busy && bus.pwm_count < 8'd255), 32'd1);
    wait_settle("down0");
    check("down0_count", 32'(bus.pwm_count), 32'd0);

    // Retarget mid-ramp, upward then downward
    press(12); wait_settle("re64");
    press(12); wait_settle("re128");
    press(12);
    wait_count(140, 1'b1, "re_up140");
    press(12);
    wait_settle("re255");
    check("re255_level", 32'(bus.level),     32'd4);
    check("re255_count", 32'(bus.pwm_count), 32'd255);
    press(12);
    wait_count(105, 1'b0, "re_dn105");
    mon_min = 255;
    press(12);
    wait_settle("re_dn64");
    check("re_dn64_level", 32'(bus.level),     32'd1);
    check("re_dn64_count", 32'(bus.pwm_count), 32'd64);
    check("re_dn64_min",   32'(mon_min),       32'd64);

    // Enable drop mid-ramp and recovery
    press(12);
    wait_count(90, 1'b1, "en_up90");
    check("en_at90", 32'(bus.pwm_count), 32'd90);
    bus.enable = 1'b0;
    step();
    check("en_off_count", 32'(bus.pwm_count), 32'd0);
    check("en_off_busy",  32'(bus.busy),      32'd0);
    ticks = 0;
    for (int k = 0; k < 8; k++) begin step(); ticks += int'(bus.pwm_tick); end
    check("en_off_ticks", 32'(ticks), 32'd0);
    press(12);
    check("en_off_level", 32'(bus.level), 32'd2);
    bus.enable = 1'b1;
    wait_settle("en_back");
    check("en_back_count", 32'(bus.pwm_count), 32'd128);

    // Reset in the middle of a ramp
    press(12);
    step();
    rst = 1'b1;
    step();
    check("midreset", 32'({bus.pwm_count, bus.level, bus.busy, bus.pwm_tick}), 32'd0);
    rst = 1'b0;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
